// File: rtl/sprite_blitter.sv
// sprite_blitter: streams a SPR_W x SPR_H colour ROM to the VGA adapter at (x0,y0),
// clipping at the screen edges and optionally skipping a transparent colour key.
module sprite_blitter #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120,
  parameter int SPR_W = 160,
  parameter int SPR_H = 120,
  parameter int ADDR_W = 15,
  parameter int COLOR_W = 3,
  parameter int ROM_LAT = 1,
  parameter bit KEY_EN = 1'b0,
  parameter logic [COLOR_W-1:0] KEY_COLOR = '0
) (
  input  logic               CLOCK_50,
  input  logic               Resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [1:0]         src_sel,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [1:0]         rom_sel,
  input  logic [COLOR_W-1:0] rom_data,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam logic [X_W-1:0] SX_LAST = X_W'(SPR_W - 1);
  localparam logic [Y_W-1:0] SY_LAST = Y_W'(SPR_H - 1);
  localparam logic [X_W:0] X_LIM = (X_W+1)'(SCR_W);
  localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCR_H);
  state_t state, state_n;
  logic [X_W-1:0] sx, ox;
  logic [Y_W-1:0] sy, oy;
  logic [ROM_LAT-1:0] dv;
  logic [X_W:0] dx [ROM_LAT];
  logic [Y_W:0] dy [ROM_LAT];
  logic issue, last, drained, vis;
  assign issue = state == SCAN && !abort;
  assign last = sx == SX_LAST && sy == SY_LAST;
  assign drained = dv == '0;
  // the tag leaving the delay line lines up with rom_data for the same address
  assign vis = dv[ROM_LAT-1] && dx[ROM_LAT-1] < X_LIM && dy[ROM_LAT-1] < Y_LIM &&
               !(KEY_EN && rom_data == KEY_COLOR);
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SCAN : IDLE;
      SCAN:    state_n = (abort || last) ? DRAIN : SCAN;
      DRAIN:   state_n = drained ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50 or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      sx <= '0;
      sy <= '0;
      ox <= '0;
      oy <= '0;
      rom_addr <= '0;
      rom_sel <= '0;
      dv <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      plot <= 1'b0;
    end else begin
      state <= state_n;
      dv <= ROM_LAT'({dv, issue});
      plot <= vis;
      if (state == IDLE && start) begin
        sx <= '0;
        sy <= '0;
        ox <= x0;
        oy <= y0;
        rom_sel <= src_sel;
        rom_addr <= '0;
      end else if (issue) begin
        sx <= sx == SX_LAST ? '0 : sx + X_W'(1);
        sy <= sx == SX_LAST ? sy + Y_W'(1) : sy;
        rom_addr <= rom_addr + ADDR_W'(1);
      end
      if (vis) begin
        vga_x <= dx[ROM_LAT-1][X_W-1:0];
        vga_y <= dy[ROM_LAT-1][Y_W-1:0];
        vga_colour <= rom_data;
      end
    end
  // one bit wider than the screen so coordinates past the edge clip instead of wrapping
  always_ff @(posedge CLOCK_50) begin
    dx[0] <= {1'b0, sx} + {1'b0, ox};
    dy[0] <= {1'b0, sy} + {1'b0, oy};
    for (int i = 1; i < ROM_LAT; i++) begin
      dx[i] <= dx[i-1];
      dy[i] <= dy[i-1];
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: three 4x2 blitters (plain, colour-keyed, 3-cycle ROM) checked against a plot scoreboard.
module tb_sprite_blitter;
  localparam int N = 8;
  localparam int LAT [3] = '{1, 1, 3};
  localparam bit KEY [3] = '{1'b0, 1'b1, 1'b0};
  typedef struct { int t; int x; int y; int c; } px_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [1:0] src_sel = '0;
  logic [14:0] addr [3];
  logic [1:0] sel [3];
  logic [2:0] data [3];
  logic [7:0] vx [3];
  logic [6:0] vy [3];
  logic [2:0] vc [3];
  logic pl [3], bz [3], dn [3];
  logic [14:0] pipe [3][4];
  px_t q [3][$];
  int exp_done [3], busy_n [3], done_n [3];
  int cyc = 0, t0 = 0, checks = 0, failures = 0;

  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ROM_LAT(1)) u_a (
    .CLOCK_50(clk), .Resetn(rst_n), .start(start), .abort(abort), .x0(x0), .y0(y0),
    .src_sel(src_sel), .rom_addr(addr[0]), .rom_sel(sel[0]), .rom_data(data[0]),
    .vga_x(vx[0]), .vga_y(vy[0]), .vga_colour(vc[0]), .plot(pl[0]), .busy(bz[0]), .done(dn[0]));
  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ROM_LAT(1), .KEY_EN(1'b1), .KEY_COLOR(3'b000)) u_k (
    .CLOCK_50(clk), .Resetn(rst_n), .start(start), .abort(abort), .x0(x0), .y0(y0),
    .src_sel(src_sel), .rom_addr(addr[1]), .rom_sel(sel[1]), .rom_data(data[1]),
    .vga_x(vx[1]), .vga_y(vy[1]), .vga_colour(vc[1]), .plot(pl[1]), .busy(bz[1]), .done(dn[1]));
  sprite_blitter #(.SPR_W(4), .SPR_H(2), .ROM_LAT(3)) u_l (
    .CLOCK_50(clk), .Resetn(rst_n), .start(start), .abort(abort), .x0(x0), .y0(y0),
    .src_sel(src_sel), .rom_addr(addr[2]), .rom_sel(sel[2]), .rom_data(data[2]),
    .vga_x(vx[2]), .vga_y(vy[2]), .vga_colour(vc[2]), .plot(pl[2]), .busy(bz[2]), .done(dn[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM with LAT-cycle read latency; colour = addr[2:0] ^ selected source
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      pipe[i][0] <= addr[i];
      for (int j = 1; j < 4; j++) pipe[i][j] <= pipe[i][j-1];
    end
  always_comb
    for (int i = 0; i < 3; i++) data[i] = pipe[i][LAT[i]-1][2:0] ^ {1'b0, sel[i]};

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n)
      for (int i = 0; i < 3; i++) begin
        px_t e;
        if (bz[i]) busy_n[i]++;
        if (pl[i]) begin
          chk($sformatf("plot_expected%0d", i), int'(q[i].size() > 0), 1);
          if (q[i].size() > 0) begin
            e = q[i].pop_front();
            chk($sformatf("plot_t%0d", i), cyc - t0, e.t);
            chk($sformatf("plot_x%0d", i), int'(vx[i]), e.x);
            chk($sformatf("plot_y%0d", i), int'(vy[i]), e.y);
            chk($sformatf("plot_c%0d", i), int'(vc[i]), e.c);
          end
        end
        if (dn[i]) begin
          chk($sformatf("done_t%0d", i), cyc - t0, exp_done[i]);
          chk($sformatf("busy_len%0d", i), busy_n[i], exp_done[i] + 1);
          chk($sformatf("left_over%0d", i), q[i].size(), 0);
          done_n[i]++;
        end
      end

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_addr"}, int'(addr[i]), 0);
      chk({tag, "_sel"}, int'(sel[i]), 0);
      chk({tag, "_x"}, int'(vx[i]), 0);
      chk({tag, "_y"}, int'(vy[i]), 0);
      chk({tag, "_c"}, int'(vc[i]), 0);
      chk({tag, "_plot"}, int'(pl[i]), 0);
      chk({tag, "_busy"}, int'(bz[i]), 0);
      chk({tag, "_done"}, int'(dn[i]), 0);
    end
  endtask

  // drives start (with a stray abort that IDLE must ignore) and loads the scoreboard
  task automatic kick(input int bx, input int by, input int bs, input int ab);
    px_t e;
    int n;
    @(negedge clk);
    x0 = 8'(bx);
    y0 = 7'(by);
    src_sel = 2'(bs);
    start = 1'b1;
    abort = 1'b1;
    n = ab < 0 ? N : ab;
    t0 = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      busy_n[i] = 0;
      q[i].delete();
      exp_done[i] = n + LAT[i] + 1;
      for (int k = 0; k < n; k++) begin
        e.t = k + LAT[i] + 1;
        e.x = bx + k % 4;
        e.y = by + k / 4;
        e.c = (k & 7) ^ bs;
        if (e.x < 160 && e.y < 120 && !(KEY[i] && e.c == 0)) q[i].push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    x0 = 8'd0;
    y0 = 7'd0;
    src_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      chk("addr_at_e0", int'(addr[i]), 0);
      chk("sel_latched", int'(sel[i]), bs);
      chk("busy_at_e0", int'(bz[i]), 1);
    end
  endtask

  task automatic blit(input int bx, input int by, input int bs, input int ab);
    int d0 [3];
    int w;
    kick(bx, by, bs, ab);
    for (int i = 0; i < 3; i++) d0[i] = done_n[i];
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (ab > 0) begin
      repeat (ab - 2) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    w = 0;
    while (w < 60 && done_n[2] == d0[2]) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("done_seen", done_n[i] - d0[i], 1);
      chk("idle_busy", int'(bz[i]), 0);
      chk("q_empty", q[i].size(), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    blit(10, 5, 0, -1);
    blit(158, 119, 0, -1);
    blit(20, 30, 0, 3);
    blit(40, 50, 2, -1);
    kick(10, 5, 1, -1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      exp_done[i] = -1;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("post_reset_busy", int'(bz[i]), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
